// File: rtl/digit_serial_addsub.sv
// Digit-serial WIDTH-bit adder/subtractor: CHUNK bits per clock, LSB chunk first.
// Latency NCHUNK cycles from accept to out_valid; the result is held in DONE until out_ready.
module digit_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             v,
  output logic             z,
  output logic             n
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [KW-1:0]      k_q, k_d;
  logic               carry_q, carry_d;
  logic               a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic               c_out_q, c_out_d, v_q, v_d, z_q, z_d, n_q, n_d;
  logic               out_valid_q, out_valid_d, in_ready_q, in_ready_d;
  logic [CHUNK:0]     chunk_s;
  logic [WIDTH-1:0]   sum_new;
  logic [WIDTH-1:0]   b_eff;

  always_comb begin
    // Only a CHUNK+1 bit adder; operands shift right so the low chunk is always the live one.
    chunk_s = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    // Result chunks enter at the top and settle into place after NCHUNK shifts.
    sum_new = (sum_q >> CHUNK) | (WIDTH'(chunk_s[CHUNK-1:0]) << (WIDTH - CHUNK));
    b_eff   = sub ? ~b : b;

    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    k_d         = k_q;
    carry_d     = carry_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    c_out_d     = c_out_q;
    v_d         = v_q;
    z_d         = z_q;
    n_d         = n_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b_eff;
          carry_d    = sub ^ c_in;
          a_msb_d    = a[WIDTH-1];
          b_msb_d    = b_eff[WIDTH-1];
          k_d        = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chunk_s[CHUNK];
        sum_d   = sum_new;
        k_d     = k_q + KW'(1);
        if (k_q == KW'(NCHUNK - 1)) begin
          c_out_d     = chunk_s[CHUNK];
          n_d         = chunk_s[CHUNK-1];
          z_d         = (sum_new == '0);
          v_d         = (a_msb_q == b_msb_q) && (chunk_s[CHUNK-1] != a_msb_q);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      k_q         <= '0;
      carry_q     <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      c_out_q     <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      k_q         <= k_d;
      carry_q     <= carry_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      c_out_q     <= c_out_d;
      v_q         <= v_d;
      z_q         <= z_d;
      n_q         <= n_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign v         = v_q;
  assign z         = z_q;
  assign n         = n_q;

endmodule
